// File: rtl/proc_bus_pkg.sv
// Shared processor-bus definitions: select codes common to the read mux and write decoder.
// Also holds the read-side FSM state type and default bus widths.
package proc_bus_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 12;

    localparam logic [2:0] SEL_AC = 3'b000;
    localparam logic [2:0] SEL_AR = 3'b001;
    localparam logic [2:0] SEL_DR = 3'b010;
    localparam logic [2:0] SEL_IR = 3'b011;
    localparam logic [2:0] SEL_PC = 3'b100;
    localparam logic [2:0] SEL_R  = 3'b101;
    localparam logic [2:0] SEL_TR = 3'b110;
    localparam logic [2:0] SEL_RA = 3'b111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        VALID    = 2'd2
    } rd_state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Memory-wait cycle counter: expired pulses during the TIMEOUT-th enabled cycle after clear.
// Saturates at TIMEOUT-1, so it never wraps; clear has priority over enable.
module mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] cnt_q, cnt_d;
    logic          at_limit;

    assign at_limit = (cnt_q == TW'(TIMEOUT - 1));
    assign expired  = enable && at_limit;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !at_limit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bus_read_mux.sv
// Drives the common bus from a selected register or from memory at AR, holding the result under valid/ack.
// Register reads land one cycle after request; RA waits on mem_ready up to TIMEOUT cycles.
module bus_read_mux
    import proc_bus_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic [2:0]        rd_sel,
    input  logic [DATA_W-1:0] ac_in,
    input  logic [DATA_W-1:0] ar_in,
    input  logic [DATA_W-1:0] dr_in,
    input  logic [DATA_W-1:0] ir_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] r_in,
    input  logic [DATA_W-1:0] tr_in,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_valid,
    input  logic              bus_ack,
    output logic              busy,
    output logic              rd_err
);

    rd_state_e         state_q, state_d;
    logic [DATA_W-1:0] bus_out_q, bus_out_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              rd_err_q, rd_err_d;
    logic [DATA_W-1:0] reg_mux;
    logic              tmr_clr;
    logic              tmr_expired;

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tmr_clr),
        .enable  (state_q == MEM_WAIT),
        .expired (tmr_expired)
    );

    always_comb begin
        reg_mux = ac_in;
        case (rd_sel)
            SEL_AC:  reg_mux = ac_in;
            SEL_AR:  reg_mux = ar_in;
            SEL_DR:  reg_mux = dr_in;
            SEL_IR:  reg_mux = ir_in;
            SEL_PC:  reg_mux = pc_in;
            SEL_R:   reg_mux = r_in;
            SEL_TR:  reg_mux = tr_in;
            default: reg_mux = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        bus_out_d  = bus_out_q;
        mem_addr_d = mem_addr_q;
        rd_err_d   = rd_err_q;
        tmr_clr    = 1'b0;
        case (state_q)
            IDLE, VALID: begin
                // In VALID a new request is only taken together with the ack of the held word.
                if (state_q == IDLE || bus_ack) begin
                    rd_err_d = 1'b0;
                    if (!rd_req) begin
                        state_d = IDLE;
                    end else if (rd_sel == SEL_RA) begin
                        mem_addr_d = ar_in[ADDR_W-1:0];
                        tmr_clr    = 1'b1;
                        state_d    = MEM_WAIT;
                    end else begin
                        bus_out_d = reg_mux;
                        state_d   = VALID;
                    end
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    bus_out_d = mem_rdata;
                    rd_err_d  = 1'b0;
                    state_d   = VALID;
                end else if (tmr_expired) begin
                    bus_out_d = '0;
                    rd_err_d  = 1'b1;
                    state_d   = VALID;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bus_out_q  <= '0;
            mem_addr_q <= '0;
            rd_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bus_out_q  <= bus_out_d;
            mem_addr_q <= mem_addr_d;
            rd_err_q   <= rd_err_d;
        end
    end

    assign bus_out   = bus_out_q;
    assign mem_addr  = mem_addr_q;
    assign rd_err    = rd_err_q;
    assign bus_valid = (state_q == VALID);
    assign mem_rd    = (state_q == MEM_WAIT);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bus_read_mux.sv
// Directed bench for bus_read_mux: register reads, hold under no-ack, memory read, timeout,
// back-to-back reads and asynchronous reset during a memory wait.
module tb_bus_read_mux;

    logic        clk;
    logic        rst_n;
    logic        rd_req;
    logic [2:0]  rd_sel;
    logic [15:0] ac_in, ar_in, dr_in, ir_in, pc_in, r_in, tr_in;
    logic        mem_rd;
    logic [11:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] bus_out;
    logic        bus_valid;
    logic        bus_ack;
    logic        busy;
    logic        rd_err;

    int checks;
    int errors;

    bus_read_mux #(.DATA_W(16), .ADDR_W(12), .TIMEOUT(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_req    (rd_req),
        .rd_sel    (rd_sel),
        .ac_in     (ac_in),
        .ar_in     (ar_in),
        .dr_in     (dr_in),
        .ir_in     (ir_in),
        .pc_in     (pc_in),
        .r_in      (r_in),
        .tr_in     (tr_in),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .bus_out   (bus_out),
        .bus_valid (bus_valid),
        .bus_ack   (bus_ack),
        .busy      (busy),
        .rd_err    (rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        rd_req = 1'b0; rd_sel = 3'b000; bus_ack = 1'b0;
        ac_in = 16'h0000; ar_in = 16'h0000; dr_in = 16'h0000; ir_in = 16'h0000;
        pc_in = 16'h0000; r_in = 16'h0000; tr_in = 16'h0000;
        mem_rdata = 16'h0000; mem_ready = 1'b0;

        @(negedge clk);
        @(negedge clk);
        check("rst_bus_out", 32'(bus_out), 32'h0);
        check("rst_valid", 32'(bus_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_mem_rd", 32'(mem_rd), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_rd_err", 32'(rd_err), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_no_req", 32'(busy), 32'h0);

        // Register read of PC
        rd_req = 1'b1; rd_sel = 3'b100; pc_in = 16'h0123;
        @(negedge clk);
        rd_req = 1'b0;
        check("pc_bus_out", 32'(bus_out), 32'h0123);
        check("pc_valid", 32'(bus_valid), 32'h1);
        check("pc_busy", 32'(busy), 32'h1);

        // Hold without ack; register changes and a stray request are ignored
        pc_in = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                rd_req = 1'b1; rd_sel = 3'b000; ac_in = 16'h1111;
            end else begin
                rd_req = 1'b0;
            end
            @(negedge clk);
            check("hold_bus_out", 32'(bus_out), 32'h0123);
            check("hold_valid", 32'(bus_valid), 32'h1);
        end
        rd_req = 1'b0; bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        check("ack_valid", 32'(bus_valid), 32'h0);
        check("ack_busy", 32'(busy), 32'h0);

        // Memory read completing on the third wait cycle
        rd_req = 1'b1; rd_sel = 3'b111; ar_in = 16'h0A5C;
        @(negedge clk);
        rd_req = 1'b0;
        check("mem_addr", 32'(mem_addr), 32'h0A5C);
        for (int i = 0; i < 3; i++) begin
            check("mem_rd_wait", 32'(mem_rd), 32'h1);
            check("mem_wait_valid", 32'(bus_valid), 32'h0);
            if (i == 2) begin
                mem_ready = 1'b1; mem_rdata = 16'hBEEF;
            end
            @(negedge clk);
        end
        mem_ready = 1'b0;
        check("mem_rd_done", 32'(mem_rd), 32'h0);
        check("mem_valid", 32'(bus_valid), 32'h1);
        check("mem_bus_out", 32'(bus_out), 32'hBEEF);
        check("mem_rd_err", 32'(rd_err), 32'h0);
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        check("mem_ack_idle", 32'(busy), 32'h0);

        // Timeout: mem_rd stays high for exactly 15 cycles
        rd_req = 1'b1; rd_sel = 3'b111; ar_in = 16'h0123;
        @(negedge clk);
        rd_req = 1'b0;
        for (int i = 0; i < 15; i++) begin
            check("to_mem_rd", 32'(mem_rd), 32'h1);
            check("to_no_valid", 32'(bus_valid), 32'h0);
            @(negedge clk);
        end
        check("to_mem_rd_low", 32'(mem_rd), 32'h0);
        check("to_valid", 32'(bus_valid), 32'h1);
        check("to_rd_err", 32'(rd_err), 32'h1);
        check("to_bus_out", 32'(bus_out), 32'h0);

        // Back-to-back register reads from VALID
        bus_ack = 1'b1; rd_req = 1'b1; rd_sel = 3'b000; ac_in = 16'h0042;
        @(negedge clk);
        check("b2b_ac_bus", 32'(bus_out), 32'h0042);
        check("b2b_ac_valid", 32'(bus_valid), 32'h1);
        check("b2b_ac_err", 32'(rd_err), 32'h0);
        rd_sel = 3'b010; dr_in = 16'h1234;
        @(negedge clk);
        check("b2b_dr_bus", 32'(bus_out), 32'h1234);
        check("b2b_dr_valid", 32'(bus_valid), 32'h1);
        rd_sel = 3'b110; tr_in = 16'h5A5A;
        @(negedge clk);
        check("b2b_tr_bus", 32'(bus_out), 32'h5A5A);
        rd_req = 1'b0;
        @(negedge clk);
        bus_ack = 1'b0;
        check("b2b_idle", 32'(busy), 32'h0);

        // Asynchronous reset during a memory wait
        rd_req = 1'b1; rd_sel = 3'b111; ar_in = 16'h0FFF;
        @(negedge clk);
        rd_req = 1'b0;
        @(negedge clk);
        check("arst_pre_mem_rd", 32'(mem_rd), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_mem_rd", 32'(mem_rd), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_valid", 32'(bus_valid), 32'h0);
        check("arst_mem_addr", 32'(mem_addr), 32'h0);
        mem_ready = 1'b1; mem_rdata = 16'hDEAD;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("late_ready_valid", 32'(bus_valid), 32'h0);
        @(negedge clk);
        mem_ready = 1'b0;
        check("late_ready_busy", 32'(busy), 32'h0);
        check("late_ready_bus", 32'(bus_out), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
